nx_node_loader: RTL and testbench
=================================

// Module: nx_node_loader
// PURPOSE
//  Upstream feeder for the node core. Accepts inbound node messages over a valid/ready handshake
//  and buffers them in a 2-entry FIFO. Decodes each message into either an instruction load (with
//  an auto-incrementing slot pointer) or an input-signal update, and drives the core's load_* and
//  in_* ports as single-cycle pulses. Flags sequencing errors to the node controller.
// PARAMETERS
//  OP_W    4    operation encoding width (matches core)
//  REG_W   16   core register count (matches core)
//  IO_W    4    core primary input/output width
//  SLOTS   32   instruction slots in core
//  INST_W  OP_W+3*$clog2(REG_W)+1+$clog2(IO_W)   instruction width (19 at defaults)
//  MSG_W   INST_W+3   message width: {TYPE[1:0], LAST, PAYLOAD[INST_W-1:0]}
// PORTS
//  clk          in   1               clock
//  rst          in   1               reset, asynchronous, active-high
//  msg_data     in   MSG_W           inbound message
//  msg_valid    in   1               inbound message valid
//  msg_ready    out  1               loader can accept (== FIFO not full)
//  stall        in   1               hold FIFO head; no decode while high
//  core_setup   in   1               core in_setup state flag
//  load_instr   out  INST_W          instruction to core
//  load_slot    out  $clog2(SLOTS)   target slot
//  load_last    out  1               final instruction of program
//  load_valid   out  1               1-cycle instruction load strobe
//  in_value     out  1               input bit value
//  in_index     out  $clog2(IO_W)    input bit index
//  in_valid     out  1               1-cycle input update strobe
//  slot_count   out  $clog2(SLOTS)+1 instructions loaded since last rewind
//  err_order    out  1               sticky: LOAD_INSTR received outside setup
//  err_overflow out  1               sticky: slot pointer exhausted without LAST
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; slot pointer 0; msg_ready=1 once rst released.
//  Handshake: push on msg_valid&&msg_ready; msg_ready=!full, no comb path from pop.
//   No push when full, even if the head pops that cycle.
//  FIFO: 2 entries, rd/wr pointers with wrap bit; push+pop same cycle keeps occupancy.
//  Pop: head popped when !empty && !stall. Decoded result registered.
//   Strobes high the cycle after pop. Min latency: accept edge -> strobe visible 2 cycles later.
//  TYPE decode on popped head:
//   2'b00 NOP: consumed, no strobe.
//   2'b01 LOAD_INSTR, core_setup=1: load_valid=1, load_instr=PAYLOAD, load_slot=ptr,
//    load_last=LAST|(ptr==SLOTS-1); ptr++ and slot_count++.
//    If ptr==SLOTS-1 && !LAST: err_overflow set.
//    After any load_last: ptr, slot_count reset to 0.
//   2'b01 LOAD_INSTR, core_setup=0: dropped, no strobe, err_order set.
//   2'b10 SIGNAL: in_valid=1, in_index=PAYLOAD[$clog2(IO_W):1], in_value=PAYLOAD[0].
//    Allowed in any core state.
//   2'b11 REWIND: ptr=0, slot_count=0, both error flags cleared; no strobe.
//  Strobes (load_valid, in_valid) are 1-cycle. Data outputs hold their last value while strobes are low.
//  stall rising with head present: head retained; at most one strobe completes.
//  Errors: sticky until REWIND or rst. They never block decode.
//  Reset mid-operation: FIFO contents discarded, strobes drop asynchronously, ptr=0.
// TESTING
//  1. Reset, 3x LOAD_INSTR (LAST on 3rd), setup=1 -> load_slot 0,1,2; load_last only on slot 2;
//     slot_count 0 after.
//  2. SIGNAL payload idx=2,val=1 -> single in_valid pulse, in_index=2, in_value=1, 2 cycles after accept.
//  3. msg_valid held high, stall=1 -> 2 accepted then msg_ready=0.
//     Release stall -> both decode in order, ready returns.
//  4. LOAD_INSTR with setup=0 -> no load_valid, err_order=1.
//     REWIND -> err_order=0, slot_count=0.
//  5. 32 LOAD_INSTR without LAST -> slot 31 has load_last=1, err_overflow=1.
//  6. Assert rst with FIFO full mid-stream -> outputs 0 immediately; after release, FIFO empty, msg_ready=1.

Source files
------------

// File: rtl/nx_node_loader_if.sv
// nx_node_loader_if: message-in / core-load-out signal bundle for the node loader.
interface nx_node_loader_if #(
  parameter int OP_W   = 4,
  parameter int REG_W  = 16,
  parameter int IO_W   = 4,
  parameter int SLOTS  = 32,
  parameter int INST_W = OP_W + 3*$clog2(REG_W) + 1 + $clog2(IO_W),
  parameter int MSG_W  = INST_W + 3
);
  logic [MSG_W-1:0]         msg_data;
  logic                     msg_valid;
  logic                     msg_ready;
  logic                     stall;
  logic                     core_setup;
  logic [INST_W-1:0]        load_instr;
  logic [$clog2(SLOTS)-1:0] load_slot;
  logic                     load_last;
  logic                     load_valid;
  logic                     in_value;
  logic [$clog2(IO_W)-1:0]  in_index;
  logic                     in_valid;
  logic [$clog2(SLOTS):0]   slot_count;
  logic                     err_order;
  logic                     err_overflow;
  modport master (
    output msg_data, msg_valid, stall, core_setup,
    input  msg_ready, load_instr, load_slot, load_last, load_valid,
           in_value, in_index, in_valid, slot_count, err_order, err_overflow
  );
  modport slave (
    input  msg_data, msg_valid, stall, core_setup,
    output msg_ready, load_instr, load_slot, load_last, load_valid,
           in_value, in_index, in_valid, slot_count, err_order, err_overflow
  );
endinterface

// File: rtl/nx_node_loader.sv
// nx_node_loader: buffers node messages in a 2-entry FIFO and decodes them into
// single-cycle instruction-load / input-update strobes for the node core.
module nx_node_loader #(
  parameter int OP_W   = 4,
  parameter int REG_W  = 16,
  parameter int IO_W   = 4,
  parameter int SLOTS  = 32,
  parameter int INST_W = OP_W + 3*$clog2(REG_W) + 1 + $clog2(IO_W),
  parameter int MSG_W  = INST_W + 3
) (
  input logic          clk,
  input logic          rst,
  nx_node_loader_if.slave bus
);
  localparam int IDX_W = $clog2(IO_W);
  localparam int PTR_W = $clog2(SLOTS);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] END_SLOT = PTR_W'(SLOTS - 1);
  logic [MSG_W-1:0]  mem [2];
  logic [1:0]        wr_ptr, rd_ptr;
  logic              full, empty, push, pop;
  logic [MSG_W-1:0]  head;
  logic [1:0]        typ;
  logic              last_in;
  logic [INST_W-1:0] payload;
  logic [PTR_W-1:0]  ptr;
  logic              do_load, do_drop, do_sig, do_rew, at_end, end_prog;
  // Ready depends only on registered pointers, so a pop never frees a slot in the same cycle.
  assign full         = (wr_ptr[1] != rd_ptr[1]) && (wr_ptr[0] == rd_ptr[0]);
  assign empty        = wr_ptr == rd_ptr;
  assign bus.msg_ready = !rst && !full;
  assign push         = bus.msg_valid && bus.msg_ready;
  assign pop          = !empty && !bus.stall;
  assign head         = mem[rd_ptr[0]];
  assign typ          = head[MSG_W-1:MSG_W-2];
  assign last_in      = head[INST_W];
  assign payload      = head[INST_W-1:0];
  assign do_load      = pop && typ == 2'b01 && bus.core_setup;
  assign do_drop      = pop && typ == 2'b01 && !bus.core_setup;
  assign do_sig       = pop && typ == 2'b10;
  assign do_rew       = pop && typ == 2'b11;
  assign at_end       = ptr == END_SLOT;
  assign end_prog     = last_in || at_end;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[0]] <= bus.msg_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      ptr              <= '0;
      bus.slot_count   <= '0;
      bus.load_instr   <= '0;
      bus.load_slot    <= '0;
      bus.load_last    <= 1'b0;
      bus.load_valid   <= 1'b0;
      bus.in_value     <= 1'b0;
      bus.in_index     <= '0;
      bus.in_valid     <= 1'b0;
      bus.err_order    <= 1'b0;
      bus.err_overflow <= 1'b0;
    end else begin
      wr_ptr         <= wr_ptr + 2'(push);
      rd_ptr         <= rd_ptr + 2'(pop);
      bus.load_valid <= do_load;
      bus.in_valid   <= do_sig;
      if (do_load) begin
        bus.load_instr <= payload;
        bus.load_slot  <= ptr;
        bus.load_last  <= end_prog;
        ptr            <= end_prog ? '0 : ptr + PTR_W'(1);
        bus.slot_count <= end_prog ? '0 : bus.slot_count + CNT_W'(1);
        if (at_end && !last_in) bus.err_overflow <= 1'b1;
      end
      if (do_drop) bus.err_order <= 1'b1;
      if (do_sig) begin
        bus.in_index <= payload[IDX_W:1];
        bus.in_value <= payload[0];
      end
      if (do_rew) begin
        ptr              <= '0;
        bus.slot_count   <= '0;
        bus.err_order    <= 1'b0;
        bus.err_overflow <= 1'b0;
      end
    end
endmodule

// File: tb/tb_nx_node_loader.sv
// tb_nx_node_loader: directed self-checking bench for nx_node_loader.
module tb_nx_node_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  nx_node_loader_if bus ();
  nx_node_loader dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [21:0] mk(input logic [1:0] t, input logic l, input logic [18:0] p);
    return {t, l, p};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [21:0] m);
    bus.msg_data  = m;
    bus.msg_valid = 1'b1;
    @(negedge clk);
    bus.msg_valid = 1'b0;
  endtask
  initial begin
    bus.msg_data   = '0;
    bus.msg_valid  = 1'b0;
    bus.stall      = 1'b0;
    bus.core_setup = 1'b1;
    #2;
    chk("rst_ready", bus.msg_ready, 0);
    chk("rst_load_valid", bus.load_valid, 0);
    chk("rst_slot_count", bus.slot_count, 0);
    chk("rst_err", {bus.err_order, bus.err_overflow}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", bus.msg_ready, 1);
    // three instruction loads, LAST on the third
    push(mk(2'b01, 1'b0, 19'h00111));
    chk("t1_latency", bus.load_valid, 0);
    @(negedge clk);
    chk("t1_lv0", bus.load_valid, 1);
    chk("t1_slot0", bus.load_slot, 0);
    chk("t1_instr0", bus.load_instr, 32'h111);
    chk("t1_last0", bus.load_last, 0);
    chk("t1_cnt1", bus.slot_count, 1);
    push(mk(2'b01, 1'b0, 19'h00222));
    chk("t1_pulse", bus.load_valid, 0);
    @(negedge clk);
    chk("t1_slot1", bus.load_slot, 1);
    chk("t1_last1", bus.load_last, 0);
    push(mk(2'b01, 1'b1, 19'h7ABCD));
    @(negedge clk);
    chk("t1_lv2", bus.load_valid, 1);
    chk("t1_slot2", bus.load_slot, 2);
    chk("t1_last2", bus.load_last, 1);
    chk("t1_instr2", bus.load_instr, 32'h7ABCD);
    chk("t1_cnt0", bus.slot_count, 0);
    // signal update idx=2 val=1
    push(mk(2'b10, 1'b0, 19'h5));
    chk("t2_latency", bus.in_valid, 0);
    @(negedge clk);
    chk("t2_iv", bus.in_valid, 1);
    chk("t2_idx", bus.in_index, 2);
    chk("t2_val", bus.in_value, 1);
    chk("t2_no_load", bus.load_valid, 0);
    @(negedge clk);
    chk("t2_pulse", bus.in_valid, 0);
    chk("t2_idx_hold", bus.in_index, 2);
    // stall fills the FIFO, release drains in order
    bus.stall     = 1'b1;
    bus.msg_valid = 1'b1;
    bus.msg_data  = mk(2'b10, 1'b0, 19'h1);
    @(negedge clk);
    chk("t3_ready_one", bus.msg_ready, 1);
    bus.msg_data = mk(2'b10, 1'b0, 19'h6);
    @(negedge clk);
    chk("t3_full", bus.msg_ready, 0);
    bus.msg_data = mk(2'b10, 1'b0, 19'h3);
    @(negedge clk);
    chk("t3_still_full", bus.msg_ready, 0);
    chk("t3_no_decode", bus.in_valid, 0);
    bus.msg_valid = 1'b0;
    bus.stall     = 1'b0;
    @(negedge clk);
    chk("t3_iv_a", bus.in_valid, 1);
    chk("t3_idx_a", bus.in_index, 0);
    chk("t3_val_a", bus.in_value, 1);
    chk("t3_ready_back", bus.msg_ready, 1);
    @(negedge clk);
    chk("t3_iv_b", bus.in_valid, 1);
    chk("t3_idx_b", bus.in_index, 3);
    chk("t3_val_b", bus.in_value, 0);
    @(negedge clk);
    chk("t3_drained", bus.in_valid, 0);
    // load outside setup, then rewind
    bus.core_setup = 1'b0;
    push(mk(2'b01, 1'b0, 19'h00042));
    @(negedge clk);
    chk("t4_dropped", bus.load_valid, 0);
    chk("t4_err_order", bus.err_order, 1);
    bus.core_setup = 1'b1;
    push(mk(2'b01, 1'b0, 19'h00043));
    @(negedge clk);
    chk("t4_load_ok", bus.load_valid, 1);
    chk("t4_cnt1", bus.slot_count, 1);
    chk("t4_sticky", bus.err_order, 1);
    push(mk(2'b11, 1'b0, 19'h0));
    @(negedge clk);
    chk("t4_rew_nostrobe", bus.load_valid, 0);
    chk("t4_rew_err", bus.err_order, 0);
    chk("t4_rew_cnt", bus.slot_count, 0);
    // 32 loads without LAST exhaust the slot pointer
    for (int i = 0; i < 32; i++) begin
      push(mk(2'b01, 1'b0, 19'(i)));
      @(negedge clk);
      chk("t5_slot", bus.load_slot, i);
      chk("t5_last", bus.load_last, (i == 31) ? 1 : 0);
    end
    chk("t5_overflow", bus.err_overflow, 1);
    chk("t5_cnt", bus.slot_count, 0);
    // reset with a full FIFO
    bus.stall = 1'b1;
    push(mk(2'b10, 1'b0, 19'h7));
    push(mk(2'b01, 1'b0, 19'h1));
    chk("t6_full", bus.msg_ready, 0);
    #2 rst = 1'b1;
    #1;
    chk("t6_lv", bus.load_valid, 0);
    chk("t6_slot", bus.load_slot, 0);
    chk("t6_ovf", bus.err_overflow, 0);
    chk("t6_last", bus.load_last, 0);
    @(negedge clk);
    rst       = 1'b0;
    bus.stall = 1'b0;
    @(negedge clk);
    chk("t6_ready", bus.msg_ready, 1);
    chk("t6_empty_iv", bus.in_valid, 0);
    @(negedge clk);
    chk("t6_empty_lv", bus.load_valid, 0);
    chk("t6_empty_iv2", bus.in_valid, 0);
    chk("t6_cnt", bus.slot_count, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
